uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter paired with `uart_rx`: serializes one byte per request as a standard 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit) on `Rs232_Tx`. Bit rate comes from the same `Baud_Set` code and 16×-oversample divisor table that `uart_rx` uses, so both ends agree on bit period at every setting. The block sits between the host byte source and the serial line.

## Interface
- No parameters; the divisor table is fixed in `uart_pkg`.
- `Clk` in 1: single system clock (50 MHz nominal).
- `Rst_n` in 1: reset, synchronous, active-low.
- `Send_En` in 1: one-cycle transmit request; accepted only while `Uart_State` = 0.
- `Data_Byte` in 8: byte to send; captured in the cycle `Send_En` is accepted.
- `Baud_Set` in 3: rate code; captured with `Data_Byte`.
- `Rs232_Tx` out 1: serial line, registered, idle high.
- `Tx_Done` out 1: one-cycle pulse at frame completion.
- `Uart_State` out 1: busy flag, high from the cycle after acceptance until frame end.

## Operation
- Rate table, with DR the divisor and BIT_CYC = 16×(DR+1) clocks per bit:
  - 0 → DR 324, 5200 (9600 Bd)
  - 1 → 162, 2608 (19200)
  - 2 → 80, 1296 (38400)
  - 3 → 53, 864 (57600)
  - 4 → 26, 432 (115200)
  - 5–7 → treated as code 0.
- FSM states:
  - IDLE → START on accepted `Send_En`.
  - START → DATA after one bit period.
  - DATA → STOP after 8 bit periods; bit index 0..7 wraps to STOP.
  - STOP → IDLE after one bit period.
- Line level per state: IDLE 1, START 0, DATA `shift[0]`, STOP 1.
- On acceptance, byte and rate are latched into internal registers. Later changes on `Data_Byte` or `Baud_Set` have no effect on the frame in flight.
- `Send_En` while busy is ignored; no queueing, no error flag.
- Bit timer: counts 0..BIT_CYC−1 and wraps. At the wrap the FSM advances and the shift register shifts right.
- Reset mid-frame: in the next cycle the line returns to 1 and state to IDLE, with no `Tx_Done`. A truncated frame is acceptable on the line.

## Timing
- Reset values: `Rs232_Tx` = 1, `Tx_Done` = 0, `Uart_State` = 0, FSM in IDLE, counters 0.
- Acceptance and bit timing:
  - `Send_En` sampled high at edge T (with `Uart_State` = 0) → `Rs232_Tx` = 0 and `Uart_State` = 1 from T+1.
  - Each bit holds exactly BIT_CYC cycles.
  - The start bit occupies T+1 .. T+BIT_CYC.
  - Data bit k begins at T+1+(k+1)·BIT_CYC.
- Frame end:
  - The stop bit ends at T+10·BIT_CYC.
  - In cycle T+10·BIT_CYC+1: `Tx_Done` = 1 for exactly one cycle, `Uart_State` = 0, line = 1.
- Back-to-back frames:
  - `Send_En` is accepted in the `Tx_Done` cycle itself.
  - The next start bit then begins in the following cycle.
  - Minimum stop-to-start idle is therefore one clock, and the frame pitch is 10·BIT_CYC + 1 cycles.
- `Send_En` and `Rst_n` = 0 in the same cycle: reset wins and the request is dropped.

## Structure
- `uart_pkg` holds:
  - `BAUD_SET_W` = 3.
  - DR constants for codes 0–4.
  - Function `bit_cycles(baud_set)` returning 16×(DR+1), with codes 5–7 mapped to code 0.
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
- `uart_rx` migrates to the same DR constants.
- One sub-module, `uart_bit_timer`, which is reusable by `uart_rx`:
  - Inputs: the latched rate and an enable.
  - Counts 0..BIT_CYC−1.
  - Emits a one-cycle `bit_tick` at the wrap.
  - Holds at 0 when not enabled.
- The top level contains the FSM, the shift register, the bit index and the output registers.

## Test plan
- **Reset:** hold `Rst_n` = 0 for 5 cycles → `Rs232_Tx` = 1, `Tx_Done` = 0, `Uart_State` = 0 throughout and after release.
- **Single frame:** `Baud_Set` = 4, `Send_En` pulse with 0xA5 → line shows 0,1,0,1,0,0,1,0,1,1, each level exactly 432 cycles; `Tx_Done` pulses once at T+4321; a looped-back `uart_rx` reports 0xA5.
- **Ignored request:** `Send_En` with 0x3C during the 0xA5 frame, and `Data_Byte`/`Baud_Set` changed mid-frame → the 0xA5 frame is bit-exact and unaltered, and no second frame follows.
- **Back-to-back:** `Send_En` with 0x00 asserted in the `Tx_Done` cycle → start bit begins the next cycle; two complete frames, each with exactly one `Tx_Done`.
- **Rate sweep:** codes 0–4 each measure 5200/2608/1296/864/432 cycles per bit; code 6 measures 5200.
- **Reset mid-frame:** `Rst_n` = 0 during data bit 3 → line = 1 and `Uart_State` = 0 the next cycle, no `Tx_Done`; a subsequent `Send_En` with 0xFF sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: rate codes, divisor constants and the transmitter state type.
// Both uart_tx and uart_rx use this table, so their bit periods always agree.
package uart_pkg;

  localparam int BAUD_SET_W = 3;
  localparam int CNT_W      = 13;

  localparam int unsigned DR_9600   = 324;
  localparam int unsigned DR_19200  = 162;
  localparam int unsigned DR_38400  = 80;
  localparam int unsigned DR_57600  = 53;
  localparam int unsigned DR_115200 = 26;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Clocks per bit: 16x oversample of (DR+1); codes 5-7 fall back to 9600 Bd.
  function automatic logic [CNT_W-1:0] bit_cycles(input logic [BAUD_SET_W-1:0] baud_set);
    int unsigned dr;
    case (baud_set)
      3'd1:    dr = DR_19200;
      3'd2:    dr = DR_38400;
      3'd3:    dr = DR_57600;
      3'd4:    dr = DR_115200;
      default: dr = DR_9600;
    endcase
    return CNT_W'(16 * (dr + 1));
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYC-1 while enabled and pulses bit_tick_o on the wrap.
// Parked at zero when disabled so every frame starts with a full first bit.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [BAUD_SET_W-1:0] baud_set_i,
  output logic                  bit_tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cnt;

  assign last_cnt   = bit_cycles(baud_set_i) - CNT_W'(1);
  assign bit_tick_o = en_i && (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: latches one byte and rate code per accepted request and
// shifts it out LSB first behind a start bit, ending with a stop bit and a Tx_Done pulse.
module uart_tx
  import uart_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Send_En,
  input  logic [7:0]            Data_Byte,
  input  logic [BAUD_SET_W-1:0] Baud_Set,
  output logic                  Rs232_Tx,
  output logic                  Tx_Done,
  output logic                  Uart_State
);

  // Handshake: Send_En is a single-cycle request, taken only when Uart_State is low;
  // requests while busy are dropped without any indication.
  tx_state_t             state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            idx_q, idx_d;
  logic [BAUD_SET_W-1:0] baud_q, baud_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_tick;

  uart_bit_timer u_bit_timer (
    .clk_i      (Clk),
    .rst_n_i    (Rst_n),
    .en_i       (state_q != IDLE),
    .baud_set_i (baud_q),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    baud_d  = baud_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Send_En) begin
          state_d = START;
          shift_d = Data_Byte;
          baud_d  = Baud_Set;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so it changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign Rs232_Tx   = tx_q;
  assign Tx_Done    = done_q;
  assign Uart_State = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, full frames at 115200, ignored requests,
// back-to-back frames, per-code start-bit lengths and reset mid-frame.
module tb_uart_tx;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Send_En;
  logic [7:0] Data_Byte;
  logic [2:0] Baud_Set;
  logic       Rs232_Tx;
  logic       Tx_Done;
  logic       Uart_State;

  int n_cmp = 0;
  int n_err = 0;

  always #10 Clk = ~Clk;

  uart_tx dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Send_En    (Send_En),
    .Data_Byte  (Data_Byte),
    .Baud_Set   (Baud_Set),
    .Rs232_Tx   (Rs232_Tx),
    .Tx_Done    (Tx_Done),
    .Uart_State (Uart_State)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request presented at a negedge, sampled at edge T; returns #1 into cycle T+1.
  task automatic send(input logic [7:0] d, input logic [2:0] b);
    @(negedge Clk);
    Send_En   = 1'b1;
    Data_Byte = d;
    Baud_Set  = b;
    @(posedge Clk);
    #1;
    Send_En = 1'b0;
  endtask

  // Checks all ten bit slots cycle by cycle; optionally pokes a request and new
  // byte/rate into the middle of data bit 3.
  task automatic check_frame(input logic [7:0] d, input int b, input string tag, input bit poke);
    logic [8:0] exp_bits;
    for (int k = 0; k < 10; k++) begin
      int   bad;
      logic lvl;
      bad = 0;
      exp_bits = {1'b1, d};
      lvl = (k == 0) ? 1'b0 : exp_bits[k-1];
      for (int j = 0; j < b; j++) begin
        @(negedge Clk);
        if (Rs232_Tx !== lvl || Uart_State !== 1'b1 || Tx_Done !== 1'b0) bad++;
        if (poke && k == 4 && j == 10) begin
          Send_En   = 1'b1;
          Data_Byte = 8'h3C;
          Baud_Set  = 3'd0;
        end else if (poke && k == 4 && j == 11) begin
          Send_En   = 1'b0;
          Data_Byte = 8'hFF;
          Baud_Set  = 3'd1;
        end
      end
      chk($sformatf("%s_bit%0d", tag, k), bad, 0);
    end
  endtask

  task automatic check_done(input string tag);
    @(negedge Clk);
    chk({tag, "_done"}, {Tx_Done, Uart_State, Rs232_Tx}, 3'b101);
  endtask

  task automatic check_quiet(input int n, input string tag);
    int bad;
    bad = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge Clk);
      if (Rs232_Tx !== 1'b1 || Uart_State !== 1'b0 || Tx_Done !== 1'b0) bad++;
    end
    chk({tag, "_quiet"}, bad, 0);
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    int sweep_bc [5];
    logic [2:0] sweep_code [5];
    sweep_code = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    sweep_bc   = '{5200, 2608, 1296, 864, 5200};

    Rst_n     = 1'b0;
    Send_En   = 1'b0;
    Data_Byte = 8'h00;
    Baud_Set  = 3'd4;

    // Reset held 5 cycles, then released.
    @(posedge Clk);
    bad = 0;
    repeat (4) begin
      @(negedge Clk);
      if ({Rs232_Tx, Tx_Done, Uart_State} !== 3'b100) bad++;
    end
    chk("reset_hold", bad, 0);
    Rst_n = 1'b1;
    check_quiet(3, "reset_release");

    // Single 0xA5 frame with an ignored request and byte/rate changes mid-frame.
    send(8'hA5, 3'd4);
    check_frame(8'hA5, 432, "a5", 1'b1);
    check_done("a5");
    @(negedge Clk);
    chk("a5_done_width", {Tx_Done, Uart_State}, 2'b00);
    check_quiet(500, "a5_after");

    // Back-to-back: 0x00 requested in the Tx_Done cycle of a 0xC3 frame.
    send(8'hC3, 3'd4);
    check_frame(8'hC3, 432, "c3", 1'b0);
    check_done("c3");
    Send_En   = 1'b1;
    Data_Byte = 8'h00;
    Baud_Set  = 3'd4;
    @(posedge Clk);
    #1;
    Send_En = 1'b0;
    check_frame(8'h00, 432, "b2b", 1'b0);
    check_done("b2b");
    @(negedge Clk);
    chk("b2b_done_width", {Tx_Done, Uart_State, Rs232_Tx}, 3'b001);

    // Reset during data bit 3 of a 0x5A frame.
    send(8'h5A, 3'd4);
    repeat (4 * 432 + 100) @(negedge Clk);
    chk("mid_pre_busy", {Uart_State, Rs232_Tx}, 2'b11);
    pulse_reset();
    @(negedge Clk);
    chk("mid_reset", {Rs232_Tx, Uart_State, Tx_Done}, 3'b100);
    check_quiet(2000, "mid_after");
    send(8'hFF, 3'd4);
    check_frame(8'hFF, 432, "ff", 1'b0);
    check_done("ff");

    // Request in the same cycle as reset is dropped.
    @(negedge Clk);
    Rst_n     = 1'b0;
    Send_En   = 1'b1;
    Data_Byte = 8'h12;
    @(posedge Clk);
    #1;
    Rst_n   = 1'b1;
    Send_En = 1'b0;
    check_quiet(20, "rst_wins");

    // Rate sweep: start bit must be low for exactly BIT_CYC cycles, then bit 0 (=1).
    for (int i = 0; i < 5; i++) begin
      send(8'h01, sweep_code[i]);
      bad = 0;
      for (int j = 0; j < sweep_bc[i]; j++) begin
        @(negedge Clk);
        if (Rs232_Tx !== 1'b0) bad++;
      end
      chk($sformatf("sweep%0d_low", sweep_code[i]), bad, 0);
      @(negedge Clk);
      chk($sformatf("sweep%0d_edge", sweep_code[i]), {Rs232_Tx, Uart_State}, 2'b11);
      pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
